// File: rtl/mips_prog_loader_checker.sv
// rtl/mips_prog_loader_checker.sv - program load, core run and masked result check controller
module mips_prog_loader_checker #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ERR_W          = 8,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              chk_valid,
  output logic              chk_ready,
  input  logic [ADDR_W-1:0] chk_addr,
  input  logic [DATA_W-1:0] chk_data,
  input  logic [DATA_W-1:0] chk_mask,
  input  logic              chk_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_run,
  input  logic              core_halted,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ERR_W-1:0]  err_count,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_CHK_REQ, S_CHK_CMP, S_DONE
  } state_t;

  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic              last_q, last_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic              pass_q, pass_d;
  logic              to_q, to_d;
  logic              mismatch;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      exp_q   <= '0;
      mask_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= '0;
      cyc_q   <= '0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    mask_d    = mask_q;
    last_d    = last_q;
    err_d     = err_q;
    cyc_d     = cyc_q;
    pass_d    = pass_q;
    to_d      = to_q;
    mismatch  = 1'b0;
    ld_ready  = 1'b0;
    chk_ready = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    core_run  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          err_d   = '0;
          cyc_d   = '0;
          pass_d  = 1'b0;
          to_d    = 1'b0;
        end
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_addr  = ld_addr;
          mem_wdata = ld_data;
          if (ld_last) state_d = S_LOAD == S_LOAD ? S_RUN : S_RUN;
        end
      end
      S_RUN: begin
        core_run = 1'b1;
        if (cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
        // A halt seen on the limit cycle still gets its results checked.
        if (core_halted) begin
          state_d = S_CHK_REQ;
        end else if (TO_EN && (cyc_q == TO_LIMIT)) begin
          to_d    = 1'b1;
          pass_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_CHK_REQ: begin
        chk_ready = 1'b1;
        if (chk_valid) begin
          mem_addr = chk_addr;
          exp_d    = chk_data;
          mask_d   = chk_mask;
          last_d   = chk_last;
          state_d  = S_CHK_CMP;
        end
      end
      S_CHK_CMP: begin
        mismatch = |((mem_rdata ^ exp_q) & mask_q);
        if (mismatch && (err_q != '1)) err_d = err_q + ERR_W'(1);
        if (last_q) begin
          state_d = S_DONE;
          pass_d  = (err_d == '0) && !to_q;
        end else begin
          state_d = S_CHK_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign pass        = pass_q;
  assign timeout     = to_q;
  assign err_count   = err_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_mips_prog_loader_checker.sv
// tb/tb_mips_prog_loader_checker.sv - directed scoreboard bench for mips_prog_loader_checker
module tb_mips_prog_loader_checker;

  typedef struct packed {
    logic        pass;
    logic        to;
    logic [7:0]  err;
    logic [15:0] cyc;
  } res_t;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_a, start_b, sel;
  logic        ld_valid, ld_last, chk_valid, chk_last;
  logic [9:0]  ld_addr, chk_addr;
  logic [31:0] ld_data, chk_data, chk_mask, mem_rdata;
  logic        core_halted;

  logic        ld_ready_a, chk_ready_a, mem_we_a, core_run_a, busy_a, done_a, pass_a, timeout_a;
  logic [9:0]  mem_addr_a;
  logic [31:0] mem_wdata_a;
  logic [7:0]  err_a;
  logic [15:0] cyc_a;
  logic        ld_ready_b, chk_ready_b, mem_we_b, core_run_b, busy_b, done_b, pass_b, timeout_b;
  logic [9:0]  mem_addr_b;
  logic [31:0] mem_wdata_b;
  logic [1:0]  err_b;
  logic [15:0] cyc_b;

  mips_prog_loader_checker u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .ld_valid(ld_valid), .ld_ready(ld_ready_a), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .chk_valid(chk_valid), .chk_ready(chk_ready_a), .chk_addr(chk_addr), .chk_data(chk_data),
    .chk_mask(chk_mask), .chk_last(chk_last),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata),
    .core_run(core_run_a), .core_halted(core_halted),
    .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(timeout_a),
    .err_count(err_a), .cycle_count(cyc_a)
  );

  mips_prog_loader_checker #(.TIMEOUT_CYCLES(16), .ERR_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .ld_valid(ld_valid), .ld_ready(ld_ready_b), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .chk_valid(chk_valid), .chk_ready(chk_ready_b), .chk_addr(chk_addr), .chk_data(chk_data),
    .chk_mask(chk_mask), .chk_last(chk_last),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata),
    .core_run(core_run_b), .core_halted(core_halted),
    .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(timeout_b),
    .err_count(err_b), .cycle_count(cyc_b)
  );

  logic        ld_ready_s, chk_ready_s, mem_we_s, core_run_s, done_s, pass_s, timeout_s;
  logic [9:0]  mem_addr_s;
  logic [31:0] mem_wdata_s;
  logic [7:0]  err_s;
  logic [15:0] cyc_s;
  assign ld_ready_s  = sel ? ld_ready_b  : ld_ready_a;
  assign chk_ready_s = sel ? chk_ready_b : chk_ready_a;
  assign mem_we_s    = sel ? mem_we_b    : mem_we_a;
  assign mem_addr_s  = sel ? mem_addr_b  : mem_addr_a;
  assign mem_wdata_s = sel ? mem_wdata_b : mem_wdata_a;
  assign core_run_s  = sel ? core_run_b  : core_run_a;
  assign done_s      = sel ? done_b      : done_a;
  assign pass_s      = sel ? pass_b      : pass_a;
  assign timeout_s   = sel ? timeout_b   : timeout_a;
  assign err_s       = sel ? {6'd0, err_b} : err_a;
  assign cyc_s       = sel ? cyc_b       : cyc_a;

  // Core model: halts on its halt_at-th released cycle and writes its result word.
  int halt_at;
  int run_cnt = 0;
  always @(posedge clk) run_cnt <= core_run_s ? run_cnt + 1 : 0;
  assign core_halted = core_run_s && (halt_at != 0) && (run_cnt >= halt_at - 1);

  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_we_s) mem[mem_addr_s] <= mem_wdata_s;
    if (core_halted) mem[121] <= 32'd130;
    mem_rdata <= mem[mem_addr_s];
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  beat_t ld_sb[$];
  res_t  res_sb[$];
  int    we_cnt = 0;
  int    chk_rdy_cnt = 0;
  int    tb_cyc = 0;
  logic  done_prev = 1'b0;

  always @(negedge clk) begin
    beat_t b;
    res_t  r;
    tb_cyc++;
    if (chk_ready_s) chk_rdy_cnt++;
    if (mem_we_s) begin
      we_cnt++;
      total++;
      assert (ld_sb.size() > 0) else begin
        bad++;
        $error("FAIL ld_unexpected_we observed_addr=0x%0h expected=no_write", mem_addr_s);
      end
      if (ld_sb.size() > 0) begin
        b = ld_sb.pop_front();
        check("ld_addr", 64'(mem_addr_s), 64'(b.a));
        check("ld_data", 64'(mem_wdata_s), 64'(b.d));
      end
    end
    if (done_s && !done_prev) begin
      total++;
      assert (res_sb.size() > 0) else begin
        bad++;
        $error("FAIL res_unexpected_done observed=1 expected=0");
      end
      if (res_sb.size() > 0) begin
        r = res_sb.pop_front();
        check("res_pass", 64'(pass_s), 64'(r.pass));
        check("res_timeout", 64'(timeout_s), 64'(r.to));
        check("res_err_count", 64'(err_s), 64'(r.err));
        check("res_cycle_count", 64'(cyc_s), 64'(r.cyc));
      end
    end
    done_prev = done_s;
  end

  logic [9:0]  la_q[$];
  logic [31:0] ldd_q[$];
  logic [9:0]  ca_q[$];
  logic [31:0] cd_q[$];
  logic [31:0] cm_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit b);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic do_load(input int spur_at);
    beat_t bt;
    check("ld_ready_in_load", 64'(ld_ready_s), 64'd1);
    for (int i = 0; i < la_q.size(); i++) begin
      while ($urandom_range(0, 2) == 0) begin
        ld_valid = 1'b0;
        tick();
      end
      if (i == spur_at) begin
        ld_valid = 1'b0;
        pulse(sel);
      end
      ld_valid = 1'b1;
      ld_addr  = la_q[i];
      ld_data  = ldd_q[i];
      ld_last  = (i == la_q.size() - 1);
      bt.a = la_q[i];
      bt.d = ldd_q[i];
      ld_sb.push_back(bt);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_checks(output int span);
    int t0 = 0;
    int t1 = 0;
    for (int i = 0; i < ca_q.size(); i++) begin
      int n = 0;
      while (!chk_ready_s && n < 200) begin
        tick();
        n++;
      end
      total++;
      assert (chk_ready_s) else begin
        bad++;
        $error("FAIL chk_ready_wait beat=%0d observed=0 expected=1", i);
      end
      chk_valid = 1'b1;
      chk_addr  = ca_q[i];
      chk_data  = cd_q[i];
      chk_mask  = cm_q[i];
      chk_last  = (i == ca_q.size() - 1);
      tick();
      if (i == 0) t0 = tb_cyc;
      t1 = tb_cyc;
      chk_valid = 1'b0;
      chk_last  = 1'b0;
    end
    span = t1 - t0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_s && n < 300) begin
      tick();
      n++;
    end
    total++;
    assert (done_s) else begin
      bad++;
      $error("FAIL %s_done_wait observed=0 expected=1", tag);
    end
    tick();
  endtask

  task automatic run_seq(input string tag, input res_t r, input int spur_at, input bit do_chk, output int span);
    int we0;
    we0 = we_cnt;
    span = 0;
    res_sb.push_back(r);
    pulse(sel);
    do_load(spur_at);
    pulse(sel);
    if (do_chk) do_checks(span);
    wait_done(tag);
    check({tag, "_we_count"}, 64'(we_cnt - we0), 64'(la_q.size()));
    check({tag, "_core_run_after_done"}, 64'(core_run_s), 64'd0);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_ctl"}, 64'({ld_ready_a, chk_ready_a, mem_we_a, core_run_a, busy_a, done_a, pass_a, timeout_a}), 64'd0);
    check({tag, "_cnt"}, 64'({err_a, cyc_a}), 64'd0);
    check({tag, "_mem"}, 64'({mem_addr_a, mem_wdata_a}), 64'd0);
  endtask

  task automatic set_prog();
    la_q  = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd120};
    ldd_q = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800, 32'h2842002d,
              32'h0c631800, 32'h24220001, 32'h00832800, 32'd85};
  endtask

  function automatic res_t mk(input logic p, input logic t, input int e, input int c);
    res_t r;
    r.pass = p;
    r.to   = t;
    r.err  = 8'(e);
    r.cyc  = 16'(c);
    return r;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int span;
    int cr0;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0; halt_at = 40;
    ld_valid = 1'b0; ld_last = 1'b0; ld_addr = '0; ld_data = '0;
    chk_valid = 1'b0; chk_last = 1'b0; chk_addr = '0; chk_data = '0; chk_mask = '0;
    repeat (3) tick();
    check_reset_a("reset_a");
    check("reset_b", 64'({core_run_b, busy_b, done_b, err_b, cyc_b}), 64'd0);
    rst_n = 1'b1;
    tick();

    set_prog();
    ca_q = '{10'd121}; cd_q = '{32'd130}; cm_q = '{32'hFFFFFFFF};
    run_seq("run_pass", mk(1, 0, 0, 40), 3, 1'b1, span);

    ca_q = '{10'd121}; cd_q = '{32'd131}; cm_q = '{32'hFFFFFFFF};
    run_seq("run_mismatch", mk(0, 0, 1, 40), -1, 1'b1, span);

    ca_q = '{10'd121, 10'd120, 10'd120};
    cd_q = '{32'd131, 32'd85, 32'hDEADBEEF};
    cm_q = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0};
    run_seq("run_masked", mk(1, 0, 0, 40), -1, 1'b1, span);

    sel = 1'b1; halt_at = 0;
    la_q  = '{10'd300, 10'd301, 10'd302, 10'd303, 10'd304};
    ldd_q = '{$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    cr0 = chk_rdy_cnt;
    run_seq("run_timeout", mk(0, 1, 0, 16), 2, 1'b0, span);
    check("timeout_no_chk_ready", 64'(chk_rdy_cnt - cr0), 64'd0);
    check("timeout_flag", 64'(timeout_b), 64'd1);

    halt_at = 5;
    la_q  = '{10'd500, 10'd501, 10'd502, 10'd503, 10'd504, 10'd505};
    ldd_q = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    ca_q  = '{10'd500, 10'd501, 10'd502, 10'd503, 10'd504, 10'd505};
    cd_q  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    cm_q  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    run_seq("run_saturate", mk(0, 0, 3, 5), -1, 1'b1, span);
    check("chk_throughput_span", 64'(span), 64'd10);

    sel = 1'b0; halt_at = 40;
    set_prog();
    res_sb.push_back(mk(1, 0, 0, 40));
    pulse(1'b0);
    do_load(-1);
    repeat (10) tick();
    check("midrun_core_run", 64'(core_run_a), 64'd1);
    rst_n = 1'b0;
    tick();
    check_reset_a("midrun_reset");
    void'(res_sb.pop_back());
    rst_n = 1'b1;
    tick();

    ca_q = '{10'd121}; cd_q = '{32'd130}; cm_q = '{32'hFFFFFFFF};
    run_seq("run_after_reset", mk(1, 0, 0, 40), -1, 1'b1, span);

    repeat (3) tick();
    check("res_sb_drained", 64'(res_sb.size()), 64'd0);
    check("ld_sb_drained", 64'(ld_sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_prog_loader_checker.md
Name: mips_prog_loader_checker

Overview:
- Synthesizable program-load / run / self-check controller for the MIPS32 pipeline core.
- Streams a program and data image into core memory while the core is held, then releases the core and waits for HALTED or a timeout.
- Reads back a list of result addresses, compares each against an expected value under a per-word mask, and reports pass/fail plus a mismatch count.
- Replaces hand-coded memory preload and $display checks, so regression runs on silicon and FPGA as well as in simulation.

Parameters:
- ADDR_W, 10, memory word-address width.
- DATA_W, 32, memory/instruction word width.
- TIMEOUT_CYCLES, 4096, maximum RUN cycles before abort; 0 disables the timeout.
- ERR_W, 8, width of the mismatch counter (saturating).
- CNT_W, 16, width of the run cycle counter.

Ports:
- clk  in  1  single system clock; all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load/run/check sequence.
- ld_valid  in  1  load beat valid.
- ld_ready  out  1  load beat accepted when ld_valid&&ld_ready.
- ld_addr  in  ADDR_W  load word address.
- ld_data  in  DATA_W  load word.
- ld_last  in  1  marks final load beat.
- chk_valid  in  1  check beat valid.
- chk_ready  out  1  check beat accepted when chk_valid&&chk_ready.
- chk_addr  in  ADDR_W  address to check.
- chk_data  in  DATA_W  expected value.
- chk_mask  in  DATA_W  bits set = compared.
- chk_last  in  1  marks final check beat.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr.
- core_run  out  1  high = core released; low = core held (PC reset, HALTED cleared by core).
- core_halted  in  1  core HALTED flag.
- busy  out  1  high in any state other than IDLE/DONE.
- done  out  1  sequence finished; held until next start.
- pass  out  1  valid when done: err_count==0 and !timeout.
- timeout  out  1  RUN aborted on cycle limit.
- err_count  out  ERR_W  masked mismatches, saturating at 2^ERR_W-1.
- cycle_count  out  CNT_W  cycles spent in RUN, saturating.

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; all outputs 0, including core_run, mem_we, ld_ready, chk_ready, done, pass, timeout and the counters. Reset mid-sequence aborts immediately; core_run drops the next edge.
- States: IDLE, LOAD, RUN, CHK_REQ, CHK_CMP, DONE.
- IDLE/DONE + start -> LOAD. Entering LOAD clears done, pass, timeout, err_count and cycle_count. start in any other state is ignored.
- LOAD:
  - ld_ready=1, core_run=0.
  - An accepted beat drives mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data in the same cycle (combinational from the handshake).
  - Accepted ld_last -> RUN.
  - core_halted is ignored.
- RUN:
  - core_run=1; cycle_count increments each cycle.
  - core_halted=1 -> CHK_REQ (core_run drops the next edge).
  - If TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1 without halt: timeout=1 -> DONE, no check phase.
  - halted and limit in the same cycle: halt wins.
- CHK_REQ:
  - chk_ready=1; an accepted beat drives mem_addr=chk_addr (mem_we=0).
  - Expected value, mask and last are registered -> CHK_CMP.
- CHK_CMP:
  - chk_ready=0.
  - Mismatch if ((mem_rdata^expected)&mask)!=0; err_count increments, saturating.
  - last -> DONE; otherwise -> CHK_REQ.
  - Throughput: one check every 2 cycles.
- DONE:
  - done=1; pass=(err_count==0)&&!timeout, registered on DONE entry.
  - core_run=0; outputs hold until start or reset.
- mem_we is asserted only in LOAD. A mask of all zeros always matches.

Test Plan:
- Load 8 words (0x28010078, 0x0c631800, 0x20220000, 0x0c631800, 0x2842002d, 0x0c631800, 0x24220001, 0x00832800) plus addr 120=85. Core model halts after 40 cycles with mem[121]=130. Check 121 expecting 130, mask 0xFFFFFFFF -> done=1, pass=1, err_count=0, cycle_count=40.
- Same run, check 121 expecting 131 -> pass=0, err_count=1. Repeat with mask 0xFFFFFFFE -> pass=1.
- TIMEOUT_CYCLES=16, core never halts -> timeout=1, pass=0, done at RUN cycle 16, chk_ready never asserted, core_run=0.
- ld_valid toggled randomly, 5 beats -> exactly 5 mem_we pulses with correct addresses/data. start pulsed during LOAD and RUN -> ignored.
- ERR_W=2, 6 mismatching checks -> err_count saturates at 3.
- rst_n=0 asserted mid-RUN -> next cycle all outputs 0, state IDLE. A subsequent start completes a normal sequence.
